// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if
//   Bundles the check-stage candidate instruction, the writeback retire
//   port and the registered issue port of the issue scheduler.
//   master : check stage / writeback / execution side (drives CHECK_*, WB_*)
//   slave  : the scheduler (drives ISSUE_*)
interface issue_scheduler_if;
   logic [31:0] CHECK_PC;
   logic [6:0]  CHECK_OPCODE;
   logic [4:0]  CHECK_RD;
   logic [4:0]  CHECK_RS1;
   logic [4:0]  CHECK_RS2;
   logic [11:0] CHECK_CSR;
   logic [2:0]  CHECK_FUNCT3;
   logic [6:0]  CHECK_FUNCT7;
   logic [31:0] CHECK_IMM;
   logic        WB_VALID;
   logic [4:0]  WB_RD;
   logic        ISSUE_VALID;
   logic [31:0] ISSUE_PC;
   logic [6:0]  ISSUE_OPCODE;
   logic [4:0]  ISSUE_RD;
   logic [4:0]  ISSUE_RS1;
   logic [4:0]  ISSUE_RS2;
   logic [11:0] ISSUE_CSR;
   logic [2:0]  ISSUE_FUNCT3;
   logic [6:0]  ISSUE_FUNCT7;
   logic [31:0] ISSUE_IMM;

   modport master (
      output CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_RS1, CHECK_RS2,
             CHECK_CSR, CHECK_FUNCT3, CHECK_FUNCT7, CHECK_IMM,
             WB_VALID, WB_RD,
      input  ISSUE_VALID, ISSUE_PC, ISSUE_OPCODE, ISSUE_RD, ISSUE_RS1,
             ISSUE_RS2, ISSUE_CSR, ISSUE_FUNCT3, ISSUE_FUNCT7, ISSUE_IMM
   );

   modport slave (
      input  CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_RS1, CHECK_RS2,
             CHECK_CSR, CHECK_FUNCT3, CHECK_FUNCT7, CHECK_IMM,
             WB_VALID, WB_RD,
      output ISSUE_VALID, ISSUE_PC, ISSUE_OPCODE, ISSUE_RD, ISSUE_RS1,
             ISSUE_RS2, ISSUE_CSR, ISSUE_FUNCT3, ISSUE_FUNCT7, ISSUE_IMM
   );
endinterface

// File: rtl/issue_scheduler.sv
// issue_scheduler
//   In-order issue stage with a register scoreboard. Holds the check stage
//   on RAW hazards, when too many register writes are outstanding, and for
//   serializing instructions (FENCE/SYSTEM) until the pipe drains.
// Ports
//   CLK, RST    : clock, asynchronous active-high reset
//   FLUSH       : synchronous flush (clears scoreboard and issue register)
//   MEM_WAIT    : global freeze; issue register holds, writeback still retires
//   bus (slave) : CHECK_* candidate, WB_VALID/WB_RD retire, ISSUE_* output
//   STALL       : combinational hold request to check stage and earlier
//   BUSY        : scoreboard, bit n set while xn has a pending write
module issue_scheduler #(
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                FLUSH,
   input  logic                MEM_WAIT,
   issue_scheduler_if.slave    bus,
   output logic                STALL,
   output logic [31:0]         BUSY
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BUBBLE = 7'b0000000;
   localparam logic [3:0] MAX_CNT   = 4'(MAX_INFLIGHT);

   typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, SERIAL = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [31:0]    busy_q, busy_d;
   logic [3:0]     count_q, count_d;
   logic           issue_valid_q, issue_valid_d;
   logic [107:0]   issue_q, issue_d;

   logic           valid_s, wr_op_s, writer_s, rs1_used_s, rs2_used_s, serial_s;
   logic           wb_hit_s, raw_s, full_s, ser_block_s, issue_s;
   logic [3:0]     count_after_s;

   // Opcode decode: which operands are read, whether rd is written, serializing.
   always_comb begin
      valid_s    = (bus.CHECK_OPCODE != OP_BUBBLE);
      wr_op_s    = 1'b0;
      rs1_used_s = 1'b0;
      rs2_used_s = 1'b0;
      serial_s   = 1'b0;
      case (bus.CHECK_OPCODE)
         OP_LUI, OP_AUIPC, OP_JAL: wr_op_s = 1'b1;
         OP_JALR, OP_LOAD, OP_IMM: begin
            wr_op_s    = 1'b1;
            rs1_used_s = 1'b1;
         end
         OP_OP: begin
            wr_op_s    = 1'b1;
            rs1_used_s = 1'b1;
            rs2_used_s = 1'b1;
         end
         OP_SYSTEM: begin
            wr_op_s    = 1'b1;
            rs1_used_s = 1'b1;
            serial_s   = 1'b1;
         end
         OP_FENCE: begin
            rs1_used_s = 1'b1;
            serial_s   = 1'b1;
         end
         OP_BRANCH, OP_STORE: begin
            rs1_used_s = 1'b1;
            rs2_used_s = 1'b1;
         end
         OP_BUBBLE: wr_op_s = 1'b0;
         default:   rs1_used_s = 1'b1;
      endcase
      writer_s = wr_op_s && (bus.CHECK_RD != 5'd0);
   end

   // Hazard detection; a retiring write releases its register in the same cycle.
   always_comb begin
      wb_hit_s      = bus.WB_VALID && (bus.WB_RD != 5'd0) && busy_q[bus.WB_RD];
      count_after_s = count_q - {3'd0, wb_hit_s};
      raw_s = (rs1_used_s && (bus.CHECK_RS1 != 5'd0) && busy_q[bus.CHECK_RS1] &&
               !(bus.WB_VALID && (bus.WB_RD == bus.CHECK_RS1))) ||
              (rs2_used_s && (bus.CHECK_RS2 != 5'd0) && busy_q[bus.CHECK_RS2] &&
               !(bus.WB_VALID && (bus.WB_RD == bus.CHECK_RS2)));
      full_s      = writer_s && (count_q == MAX_CNT) && !wb_hit_s;
      ser_block_s = serial_s && (count_after_s != 4'd0);
      STALL   = valid_s && !FLUSH && (raw_s || full_s || ser_block_s || MEM_WAIT);
      issue_s = valid_s && !STALL && !FLUSH;
   end

   // Scoreboard and issue-register next state; issue-set wins over WB-clear.
   always_comb begin
      busy_d        = busy_q;
      count_d       = count_q;
      issue_valid_d = issue_valid_q;
      issue_d       = issue_q;
      if (FLUSH) begin
         busy_d        = 32'd0;
         count_d       = 4'd0;
         issue_valid_d = 1'b0;
         issue_d       = 108'd0;
      end else begin
         if (wb_hit_s) begin
            busy_d[bus.WB_RD] = 1'b0;
         end else begin
            busy_d = busy_d;
         end
         if (issue_s && writer_s) begin
            busy_d[bus.CHECK_RD] = 1'b1;
         end else begin
            busy_d = busy_d;
         end
         count_d = count_q + {3'd0, issue_s && writer_s} - {3'd0, wb_hit_s};
         if (MEM_WAIT) begin
            issue_valid_d = issue_valid_q;
         end else if (issue_s) begin
            issue_valid_d = 1'b1;
            issue_d = {bus.CHECK_PC, bus.CHECK_OPCODE, bus.CHECK_RD, bus.CHECK_RS1,
                       bus.CHECK_RS2, bus.CHECK_CSR, bus.CHECK_FUNCT3,
                       bus.CHECK_FUNCT7, bus.CHECK_IMM};
         end else begin
            issue_valid_d = 1'b0;
            issue_d       = 108'd0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // FSM next state: tracks why the check stage is being held.
   always_comb begin
      state_d = state_q;
      if (FLUSH) begin
         state_d = RUN;
      end else if (MEM_WAIT) begin
         state_d = state_q;
      end else begin
         case (state_q)
            RUN: begin
               if (valid_s && (raw_s || full_s)) begin
                  state_d = HOLD;
               end else if (valid_s && ser_block_s) begin
                  state_d = SERIAL;
               end else begin
                  state_d = RUN;
               end
            end
            HOLD, SERIAL: begin
               if (issue_s || !valid_s) begin
                  state_d = RUN;
               end else begin
                  state_d = state_q;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= RUN;
         busy_q        <= 32'd0;
         count_q       <= 4'd0;
         issue_valid_q <= 1'b0;
         issue_q       <= 108'd0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         count_q       <= count_d;
         issue_valid_q <= issue_valid_d;
         issue_q       <= issue_d;
      end
   end

   assign BUSY            = busy_q;
   assign bus.ISSUE_VALID = issue_valid_q;
   assign {bus.ISSUE_PC, bus.ISSUE_OPCODE, bus.ISSUE_RD, bus.ISSUE_RS1,
           bus.ISSUE_RS2, bus.ISSUE_CSR, bus.ISSUE_FUNCT3,
           bus.ISSUE_FUNCT7, bus.ISSUE_IMM} = issue_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler
//   Directed scenarios plus a randomized run against a scoreboard model
//   expressed with a plain bit vector and an integer count.
module tb_issue_scheduler;
   localparam int MAXI = 4;
   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                          JALR = 7'b1100111, LOAD = 7'b0000011, ADDI = 7'b0010011,
                          ADD = 7'b0110011, SYS = 7'b1110011, FENCE = 7'b0001111,
                          BR = 7'b1100011, ST = 7'b0100011;

   logic        CLK = 1'b0;
   logic        RST, FLUSH, MEM_WAIT, STALL;
   logic [31:0] BUSY;
   issue_scheduler_if bus();

   issue_scheduler #(.MAX_INFLIGHT(MAXI)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
      .bus(bus.slave), .STALL(STALL), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [31:0]  m_busy;
   int           m_count;
   logic         m_iv;
   logic [107:0] m_out;

   function automatic logic [107:0] check_vec();
      return {bus.CHECK_PC, bus.CHECK_OPCODE, bus.CHECK_RD, bus.CHECK_RS1, bus.CHECK_RS2,
              bus.CHECK_CSR, bus.CHECK_FUNCT3, bus.CHECK_FUNCT7, bus.CHECK_IMM};
   endfunction

   function automatic logic [107:0] issue_vec();
      return {bus.ISSUE_PC, bus.ISSUE_OPCODE, bus.ISSUE_RD, bus.ISSUE_RS1, bus.ISSUE_RS2,
              bus.ISSUE_CSR, bus.ISSUE_FUNCT3, bus.ISSUE_FUNCT7, bus.ISSUE_IMM};
   endfunction

   function automatic bit pend(input logic [4:0] r);
      return (r != 5'd0) && m_busy[r] && !(bus.WB_VALID && bus.WB_RD == r);
   endfunction

   function automatic bit m_writer();
      return (bus.CHECK_OPCODE inside {LUI, AUIPC, JAL, JALR, LOAD, ADDI, ADD, SYS}) &&
             (bus.CHECK_RD != 5'd0);
   endfunction

   function automatic bit m_wdec();
      return bus.WB_VALID && (bus.WB_RD != 5'd0) && m_busy[bus.WB_RD];
   endfunction

   function automatic bit m_stall();
      logic [6:0] op;
      bit valid, r1, r2, raw, full, ser;
      int after;
      op    = bus.CHECK_OPCODE;
      valid = (op != 7'd0);
      after = m_count - int'(m_wdec());
      r1    = valid && !(op inside {LUI, AUIPC, JAL});
      r2    = op inside {BR, ST, ADD};
      raw   = (r1 && pend(bus.CHECK_RS1)) || (r2 && pend(bus.CHECK_RS2));
      full  = m_writer() && (m_count == MAXI) && !m_wdec();
      ser   = (op inside {FENCE, SYS}) && (after != 0);
      return !FLUSH && valid && (raw || full || ser || MEM_WAIT);
   endfunction

   function automatic void model_reset();
      m_busy = 32'd0; m_count = 0; m_iv = 1'b0; m_out = 108'd0;
   endfunction

   // advance one clock, updating the model from the inputs seen at the edge
   task automatic tick();
      bit valid, wr, wd, iss;
      logic [107:0] cur;
      valid = (bus.CHECK_OPCODE != 7'd0);
      wr    = m_writer();
      wd    = m_wdec();
      iss   = valid && !m_stall() && !FLUSH;
      cur   = check_vec();
      @(posedge CLK);
      if (FLUSH) begin
         model_reset();
      end else begin
         if (wd) begin m_busy[bus.WB_RD] = 1'b0; m_count--; end
         if (iss && wr) begin m_busy[bus.CHECK_RD] = 1'b1; m_count++; end
         if (!MEM_WAIT) begin
            m_iv  = iss;
            m_out = iss ? cur : 108'd0;
         end
      end
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
      bus.CHECK_OPCODE = op;  bus.CHECK_RD = rd;
      bus.CHECK_RS1 = rs1;    bus.CHECK_RS2 = rs2;
      bus.CHECK_PC = $urandom; bus.CHECK_IMM = $urandom;
      bus.CHECK_CSR = 12'($urandom); bus.CHECK_FUNCT3 = 3'($urandom);
      bus.CHECK_FUNCT7 = 7'($urandom);
      #1;
   endtask

   task automatic bubble();
      bus.CHECK_OPCODE = 7'd0; bus.CHECK_RD = 5'd0; bus.CHECK_RS1 = 5'd0;
      bus.CHECK_RS2 = 5'd0; bus.CHECK_PC = 32'd0; bus.CHECK_IMM = 32'd0;
      bus.CHECK_CSR = 12'd0; bus.CHECK_FUNCT3 = 3'd0; bus.CHECK_FUNCT7 = 7'd0;
      #1;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] rd);
      bus.WB_VALID = v; bus.WB_RD = rd; #1;
   endtask

   task automatic clean();
      bubble(); set_wb(1'b0, 5'd0); MEM_WAIT = 1'b0;
      FLUSH = 1'b1; tick(); FLUSH = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; FLUSH = 1'b0; MEM_WAIT = 1'b0;
      bubble(); set_wb(1'b0, 5'd0); model_reset();
      #2;
      checks++; if (BUSY !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", BUSY); end
      checks++; if (bus.ISSUE_VALID !== 1'b0 || issue_vec() !== 108'd0) begin errors++; $display("FAIL reset_issue got %b/%h want 0", bus.ISSUE_VALID, issue_vec()); end
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", STALL); end
      checks++; if (dut.count_q !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dut.count_q); end
      @(negedge CLK); RST = 1'b0; #1;
   endtask

   task automatic test_raw();
      logic [107:0] add_v;
      clean();
      set_instr(ADDI, 5'd5, 5'd0, 5'd0); tick();
      checks++; if (BUSY !== 32'h20) begin errors++; $display("FAIL raw_busy5 got %h want 00000020", BUSY); end
      set_instr(ADD, 5'd6, 5'd5, 5'd1); add_v = check_vec();
      for (int i = 0; i < 2; i++) begin
         checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL raw_stall got %b want 1", STALL); end
         tick();
      end
      checks++; if (bus.ISSUE_VALID !== 1'b0) begin errors++; $display("FAIL raw_noissue got %b want 0", bus.ISSUE_VALID); end
      set_wb(1'b1, 5'd5);
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL raw_release got %b want 0", STALL); end
      tick(); set_wb(1'b0, 5'd0); bubble();
      checks++; if (bus.ISSUE_VALID !== 1'b1 || issue_vec() !== add_v) begin errors++; $display("FAIL raw_issue got %b/%h want 1/%h", bus.ISSUE_VALID, issue_vec(), add_v); end
      checks++; if (BUSY !== 32'h40) begin errors++; $display("FAIL raw_busy6 got %h want 00000040", BUSY); end
   endtask

   task automatic test_full();
      clean();
      for (int r = 1; r <= 4; r++) begin set_instr(ADDI, 5'(r), 5'd0, 5'd0); tick(); end
      set_instr(ADDI, 5'd5, 5'd0, 5'd0);
      checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", STALL); end
      checks++; if (dut.count_q !== 4'd4) begin errors++; $display("FAIL full_count got %0d want 4", dut.count_q); end
      tick();
      set_wb(1'b1, 5'd1);
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL full_release got %b want 0", STALL); end
      tick(); set_wb(1'b0, 5'd0); bubble();
      checks++; if (dut.count_q !== 4'd4 || BUSY !== 32'h3C) begin errors++; $display("FAIL full_after got cnt %0d busy %h want 4/0000003c", dut.count_q, BUSY); end
      checks++; if (bus.ISSUE_VALID !== 1'b1 || bus.ISSUE_RD !== 5'd5) begin errors++; $display("FAIL full_issue got %b rd %0d want 1 rd 5", bus.ISSUE_VALID, bus.ISSUE_RD); end
   endtask

   task automatic test_fence();
      clean();
      set_instr(ADDI, 5'd1, 5'd0, 5'd0); tick();
      set_instr(ADDI, 5'd2, 5'd0, 5'd0); tick();
      set_instr(FENCE, 5'd0, 5'd0, 5'd0);
      checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL fence_stall got %b want 1", STALL); end
      tick();
      set_wb(1'b1, 5'd1);
      checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL fence_stall1 got %b want 1", STALL); end
      tick(); set_wb(1'b1, 5'd2);
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL fence_drain got %b want 0", STALL); end
      tick(); set_wb(1'b0, 5'd0); bubble();
      checks++; if (bus.ISSUE_VALID !== 1'b1 || bus.ISSUE_OPCODE !== FENCE || dut.count_q !== 4'd0) begin errors++; $display("FAIL fence_issue got %b op %b cnt %0d want 1 op 0001111 cnt 0", bus.ISSUE_VALID, bus.ISSUE_OPCODE, dut.count_q); end
   endtask

   task automatic test_mem_wait();
      logic [107:0] addi_v, add_v;
      clean();
      set_instr(ADDI, 5'd5, 5'd0, 5'd0); addi_v = check_vec(); tick();
      set_instr(ADD, 5'd6, 5'd5, 5'd1); add_v = check_vec();
      MEM_WAIT = 1'b1; set_wb(1'b1, 5'd5);
      checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL mw_stall got %b want 1", STALL); end
      tick(); set_wb(1'b0, 5'd0);
      checks++; if (BUSY !== 32'd0) begin errors++; $display("FAIL mw_wb got %h want 0", BUSY); end
      checks++; if (bus.ISSUE_VALID !== 1'b1 || issue_vec() !== addi_v) begin errors++; $display("FAIL mw_hold got %b/%h want 1/%h", bus.ISSUE_VALID, issue_vec(), addi_v); end
      MEM_WAIT = 1'b0; #1;
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL mw_drop got %b want 0", STALL); end
      tick(); bubble();
      checks++; if (bus.ISSUE_VALID !== 1'b1 || issue_vec() !== add_v) begin errors++; $display("FAIL mw_issue got %b/%h want 1/%h", bus.ISSUE_VALID, issue_vec(), add_v); end
   endtask

   task automatic test_flush();
      clean();
      for (int r = 5; r <= 7; r++) begin set_instr(ADDI, 5'(r), 5'd0, 5'd0); tick(); end
      checks++; if (BUSY !== 32'hE0 || dut.count_q !== 4'd3) begin errors++; $display("FAIL fl_pre got %h cnt %0d want 000000e0 cnt 3", BUSY, dut.count_q); end
      set_instr(ADD, 5'd8, 5'd5, 5'd6); FLUSH = 1'b1; #1;
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL fl_stall got %b want 0", STALL); end
      tick(); FLUSH = 1'b0; #1;
      checks++; if (BUSY !== 32'd0 || dut.count_q !== 4'd0 || bus.ISSUE_VALID !== 1'b0) begin errors++; $display("FAIL fl_clear got %h cnt %0d iv %b want 0", BUSY, dut.count_q, bus.ISSUE_VALID); end
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL fl_after got %b want 0", STALL); end
      tick(); bubble();
   endtask

   task automatic test_async_reset();
      logic [107:0] add_v;
      clean();
      set_instr(ADDI, 5'd5, 5'd0, 5'd0); tick();
      set_instr(ADD, 5'd6, 5'd5, 5'd1); add_v = check_vec(); tick();
      checks++; if (BUSY !== 32'h20 || STALL !== 1'b1) begin errors++; $display("FAIL ar_pre got %h stall %b want 00000020 stall 1", BUSY, STALL); end
      #2 RST = 1'b1; #1;
      model_reset();
      checks++; if (BUSY !== 32'd0 || bus.ISSUE_VALID !== 1'b0 || issue_vec() !== 108'd0) begin errors++; $display("FAIL ar_zero got %h iv %b want 0", BUSY, bus.ISSUE_VALID); end
      checks++; if (dut.count_q !== 4'd0 || STALL !== 1'b0) begin errors++; $display("FAIL ar_state got cnt %0d stall %b want 0", dut.count_q, STALL); end
      #1 RST = 1'b0; #1;
      tick(); bubble();
      checks++; if (bus.ISSUE_VALID !== 1'b1 || issue_vec() !== add_v) begin errors++; $display("FAIL ar_recover got %b/%h want 1/%h", bus.ISSUE_VALID, issue_vec(), add_v); end
   endtask

   task automatic test_random();
      logic [6:0] ops [12];
      ops = '{7'd0, LUI, AUIPC, JAL, JALR, LOAD, ADDI, ADD, SYS, FENCE, BR, ST};
      clean();
      for (int c = 0; c < 600; c++) begin
         set_instr(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (bus.CHECK_OPCODE == 7'd0) bubble();
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         MEM_WAIT = ($urandom_range(0, 9) == 0);
         FLUSH    = ($urandom_range(0, 39) == 0);
         #1;
         checks++; if (STALL !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, STALL, m_stall()); end
         tick();
         checks++; if (BUSY !== m_busy || dut.count_q !== 4'(m_count)) begin errors++; $display("FAIL rnd_sb cyc %0d got %h/%0d want %h/%0d", c, BUSY, dut.count_q, m_busy, m_count); end
         checks++; if (bus.ISSUE_VALID !== m_iv || issue_vec() !== m_out) begin errors++; $display("FAIL rnd_issue cyc %0d got %b/%h want %b/%h", c, bus.ISSUE_VALID, issue_vec(), m_iv, m_out); end
      end
      FLUSH = 1'b0; MEM_WAIT = 1'b0; set_wb(1'b0, 5'd0); bubble();
   endtask

   initial begin
      test_reset();
      test_raw();
      test_full();
      test_fence();
      test_mem_wait();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
